// File: rtl/sine_pkg.sv
// Shared definitions for the sine-wave layer sequencer: FSM state encoding,
// vertical direction encoding and default layer geometry.
package sine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } anim_state_e;

  typedef enum logic {
    VDIR_DOWN = 1'b0,
    VDIR_UP   = 1'b1
  } vdir_e;

  localparam int BAND_ROWS = 19;
  localparam int LX_W      = 6;
  localparam int LY_W      = 5;

endpackage

// File: rtl/sine_anim_fsm.sv
// Per-frame animation of the sine band: horizontal phase scroll and a vertical
// bounce with a pause at each end. Every register moves only on frame_start.
module sine_anim_fsm
  import sine_pkg::*;
#(
  parameter int V_CELLS      = 60,
  parameter int BAND_ROWS_P  = BAND_ROWS,
  parameter int STEP_SHIFT   = 1,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            run,
  input  logic            dir,
  output logic [LX_W-1:0] phase,
  output logic [5:0]      band_top,
  output logic [1:0]      state_dbg
);

  localparam int DIV_W = (STEP_SHIFT > 0) ? STEP_SHIFT : 1;
  localparam int PC_W  = $clog2(PAUSE_FRAMES + 1);
  localparam logic [5:0] BAND_MAX = 6'(V_CELLS - BAND_ROWS_P);

  anim_state_e      state_q, state_d;
  logic [DIV_W-1:0] frame_div_q, frame_div_d;
  logic [PC_W-1:0]  pause_cnt_q, pause_cnt_d;
  logic [LX_W-1:0]  phase_q, phase_d;
  logic [5:0]       band_top_q, band_top_d;
  vdir_e            vdir_q, vdir_d;

  logic [DIV_W-1:0] div_inc;
  logic             step;
  logic [5:0]       band_next;
  logic [LX_W-1:0]  phase_next;
  logic             at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_div_q <= '0;
      pause_cnt_q <= '0;
      phase_q     <= '0;
      band_top_q  <= '0;
      vdir_q      <= VDIR_DOWN;
    end else begin
      state_q     <= state_d;
      frame_div_q <= frame_div_d;
      pause_cnt_q <= pause_cnt_d;
      phase_q     <= phase_d;
      band_top_q  <= band_top_d;
      vdir_q      <= vdir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_div_d = frame_div_q;
    pause_cnt_d = pause_cnt_q;
    phase_d     = phase_q;
    band_top_d  = band_top_q;
    vdir_d      = vdir_q;

    div_inc    = frame_div_q + DIV_W'(1);
    step       = (STEP_SHIFT == 0) || (div_inc == '0);
    phase_next = dir ? (phase_q - LX_W'(1)) : (phase_q + LX_W'(1));
    // Saturate at the limits so a restart from either end stays in range.
    if (vdir_q == VDIR_DOWN) begin
      band_next = (band_top_q == BAND_MAX) ? band_top_q : (band_top_q + 6'd1);
    end else begin
      band_next = (band_top_q == 6'd0) ? band_top_q : (band_top_q - 6'd1);
    end
    at_end = ((vdir_q == VDIR_DOWN) && (band_next == BAND_MAX)) ||
             ((vdir_q == VDIR_UP) && (band_next == 6'd0));

    if (frame_start) begin
      frame_div_d = div_inc;
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d     = ST_RUN;
            vdir_d      = VDIR_DOWN;
            frame_div_d = '0;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_d     = ST_IDLE;
            pause_cnt_d = '0;
          end else if (step) begin
            phase_d    = phase_next;
            band_top_d = band_next;
            if (at_end) begin
              state_d     = ST_HOLD;
              pause_cnt_d = PC_W'(PAUSE_FRAMES - 1);
              vdir_d      = (vdir_q == VDIR_DOWN) ? VDIR_UP : VDIR_DOWN;
            end
          end
        end
        ST_HOLD: begin
          if (!run) begin
            state_d     = ST_IDLE;
            pause_cnt_d = '0;
          end else begin
            if (step) phase_d = phase_next;
            if (pause_cnt_q == '0) state_d = ST_RUN;
            else pause_cnt_d = pause_cnt_q - PC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign phase     = phase_q;
  assign band_top  = band_top_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/sine_scroll_sequencer.sv
// Maps raster positions to sine-layer cell coordinates through one register stage.
// Optional shear of the band enabled by defining SINE_SCROLL_SEQUENCER_WOBBLE_EN.
module sine_scroll_sequencer
  import sine_pkg::*;
#(
  parameter int SCALE_SHIFT  = 3,
  parameter int V_ACTIVE     = 480,
  parameter int BAND_ROWS    = sine_pkg::BAND_ROWS,
  parameter int STEP_SHIFT   = 1,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            pix_valid,
  input  logic [9:0]      hpos,
  input  logic [9:0]      vpos,
  input  logic            run,
  input  logic            dir,
  output logic [LX_W-1:0] layer_x,
  output logic [LY_W-1:0] layer_y,
  output logic            layer_en,
  output logic [1:0]      state_dbg
);

  localparam int V_CELLS = V_ACTIVE >> SCALE_SHIFT;
  localparam logic signed [6:0] REL_MAX = 7'(BAND_ROWS - 1);

  logic [LX_W-1:0] phase;
  logic [5:0]      band_top;

  sine_anim_fsm #(
    .V_CELLS     (V_CELLS),
    .BAND_ROWS_P (BAND_ROWS),
    .STEP_SHIFT  (STEP_SHIFT),
    .PAUSE_FRAMES(PAUSE_FRAMES)
  ) u_anim (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .run        (run),
    .dir        (dir),
    .phase      (phase),
    .band_top   (band_top),
    .state_dbg  (state_dbg)
  );

  logic [LX_W-1:0]    cell_x;
  logic [6:0]         cell_y;
  logic signed [6:0]  rel;
  logic [LX_W-1:0]    wob;
  logic [LX_W-1:0]    layer_x_d, layer_x_q;
  logic [LY_W-1:0]    layer_y_d, layer_y_q;
  logic               layer_en_d, layer_en_q;

  // phase/band_top are the values before any frame_start update this cycle.
  always_comb begin
    cell_x     = LX_W'(hpos >> SCALE_SHIFT);
    cell_y     = 7'(vpos >> SCALE_SHIFT);
    rel        = $signed(cell_y - {1'b0, band_top});
    layer_en_d = pix_valid && (rel >= 7'sd0) && (rel <= REL_MAX);
    layer_y_d  = layer_en_d ? rel[LY_W-1:0] : '0;
`ifdef SINE_SCROLL_SEQUENCER_WOBBLE_EN
    wob = phase[5] ? (LX_W'(0) - {3'b000, rel[4:2]}) : {3'b000, rel[4:2]};
`else
    wob = '0;
`endif
    layer_x_d = cell_x + phase + wob;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_x_q  <= '0;
      layer_y_q  <= '0;
      layer_en_q <= 1'b0;
    end else begin
      layer_x_q  <= layer_x_d;
      layer_y_q  <= layer_y_d;
      layer_en_q <= layer_en_d;
    end
  end

  assign layer_x  = layer_x_q;
  assign layer_y  = layer_y_q;
  assign layer_en = layer_en_q;

endmodule

// File: tb/tb_sine_scroll_sequencer.sv
// Self-checking bench for sine_scroll_sequencer: directed steps plus random
// frames/pixels compared against an arithmetic model of the animation rules.
module tb_sine_scroll_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       run;
  logic       dir;
  logic [5:0] layer_x;
  logic [4:0] layer_y;
  logic       layer_en;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // model of animation state: 0 idle, 1 run, 2 hold; vdir 0 down, 1 up
  int m_state, m_phase, m_band, m_vdir, m_pause, m_frames;

  sine_scroll_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .hpos       (hpos),
    .vpos       (vpos),
    .run        (run),
    .dir        (dir),
    .layer_x    (layer_x),
    .layer_y    (layer_y),
    .layer_en   (layer_en),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_band = 0; m_vdir = 0; m_pause = 0; m_frames = 0;
  endtask

  // m_frames counts frame_starts since entering RUN; a step is every 2nd one.
  task automatic model_frame(input bit r, input bit d);
    bit stp;
    if (m_state == 0) begin
      if (r) begin m_state = 1; m_vdir = 0; m_frames = 0; end
    end else if (!r) begin
      m_state = 0; m_pause = 0;
    end else begin
      m_frames++;
      stp = (m_frames % 2) == 0;
      if (stp) m_phase = (m_phase + (d ? 63 : 1)) % 64;
      if (m_state == 1) begin
        if (stp) begin
          if (m_vdir == 0) m_band = (m_band < 41) ? m_band + 1 : 41;
          else             m_band = (m_band > 0) ? m_band - 1 : 0;
          if ((m_vdir == 0 && m_band == 41) || (m_vdir == 1 && m_band == 0)) begin
            m_state = 2; m_pause = 29; m_vdir = 1 - m_vdir;
          end
        end
      end else begin
        if (m_pause == 0) m_state = 1;
        else m_pause--;
      end
    end
  endtask

  task automatic frame(input bit r, input bit d);
    @(negedge clk);
    frame_start = 1'b1; pix_valid = 1'b0; run = r; dir = d;
    @(negedge clk);
    frame_start = 1'b0;
    model_frame(r, d);
    chk("state_dbg", 32'(state_dbg), 32'(m_state));
  endtask

  task automatic pix(input int h, input int v, input bit val);
    int rel, w, ex, ey;
    bit een;
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); pix_valid = val;
    rel = (v / 8) - m_band;
    rel = ((rel % 128) + 128) % 128;
    if (rel >= 64) rel -= 128;
    een = val && rel >= 0 && rel <= 18;
    ey  = een ? (rel & 31) : 0;
`ifdef SINE_SCROLL_SEQUENCER_WOBBLE_EN
    w = (rel & 28) >> 2;
    if (m_phase >= 32) w = (64 - w) % 64;
`else
    w = 0;
`endif
    ex = ((h / 8) + m_phase + w) % 64;
    @(negedge clk);
    chk("layer_x", 32'(layer_x), 32'(ex));
    chk("layer_y", 32'(layer_y), 32'(ey));
    chk("layer_en", 32'(layer_en), 32'(een));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 32'(layer_x), 0);
    chk({tag, "_y"}, 32'(layer_y), 0);
    chk({tag, "_en"}, 32'(layer_en), 0);
    chk({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
    #1;
    model_reset();
    chk_all_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    hpos = '0; vpos = '0; run = 1'b0; dir = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // cell mapping with the band at its reset position
    pix(100, 40, 1'b1);
    chk("map_x12", 32'(layer_x), 12);
    chk("map_y5", 32'(layer_y), 5);
    chk("map_en1", 32'(layer_en), 1);
    pix(100, 160, 1'b1);
    chk("map_out_en", 32'(layer_en), 0);
    chk("map_out_y", 32'(layer_y), 0);
    pix(100, 40, 1'b0);
    chk("map_blank_en", 32'(layer_en), 0);

    // backwards scroll wraps 0 -> 63
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b1);
    pix(0, 8, 1'b1);
    chk("wrap_x63", 32'(layer_x), 63);

    // forward to phase 17, then reset in the middle of RUN
    repeat (36) frame(1'b1, 1'b0);
    pix(0, m_band * 8, 1'b1);
    chk("phase17", 32'(layer_x), 17);
    do_reset();
    frame(1'b1, 1'b0);
    chk("rst_run", 32'(state_dbg), 1);
    pix(0, 0, 1'b1);
    chk("rst_nostep", 32'(layer_x), 0);

    // randomized frames and pixels
    repeat (60) begin
      frame(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
      repeat (2) pix($urandom_range(0, 639), $urandom_range(0, 479), ($urandom_range(0, 3) != 0));
    end

    // bounce to the bottom, pause, then head back up
    do_reset();
    frame(1'b1, 1'b0);
    repeat (82) frame(1'b1, 1'b0);
    chk("bounce_hold", 32'(state_dbg), 2);
    pix(0, 41 * 8, 1'b1);
    chk("bounce_41_en", 32'(layer_en), 1);
    chk("bounce_41_y", 32'(layer_y), 0);
    pix(0, 40 * 8, 1'b1);
    chk("bounce_40_out", 32'(layer_en), 0);
    repeat (29) frame(1'b1, 1'b0);
    chk("hold_29", 32'(state_dbg), 2);
    frame(1'b1, 1'b0);
    chk("hold_release", 32'(state_dbg), 1);
    repeat (2) frame(1'b1, 1'b0);
    pix(0, 40 * 8, 1'b1);
    chk("back_40_en", 32'(layer_en), 1);
    pix(0, 41 * 8, 1'b1);
    chk("back_40_y", 32'(layer_y), 1);

    // stop during the pause: everything freezes
    do_reset();
    frame(1'b1, 1'b0);
    repeat (92) frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    chk("stop_idle", 32'(state_dbg), 0);
    repeat (5) begin
      frame(1'b0, 1'($urandom_range(0, 1)));
      pix(16, 41 * 8, 1'b1);
      chk("stop_band41", 32'(layer_en), 1);
    end

`ifdef SINE_SCROLL_SEQUENCER_WOBBLE_EN
    do_reset();
    pix(0, 64, 1'b1);
    chk("wobble_pos", 32'(layer_x), 2);
    frame(1'b1, 1'b0);
    repeat (64) frame(1'b1, 1'b0);
    pix(0, (32 + 8) * 8, 1'b1);
    chk("wobble_neg", 32'(layer_x), 30);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
